// File: rtl/symcounter_pkg.sv
// Shared definitions for the countdown sequencer: FSM states, blank pattern,
// and the active-low 7-segment digit table.
package symcounter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Returns 10**n; used to find the largest value N digits can show.
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Active-low {g..a} pattern for one BCD digit; anything above 9 is blank.
    function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/period_countdown_seq_if.sv
// Control and display bundle between the phase FSM (master) and the
// countdown sequencer (slave).
interface period_countdown_seq_if #(
    parameter int N_DIGITS = 2,
    parameter int LEVEL_W  = 4
);
    logic                  Clk1Hz;
    logic                  start;
    logic                  pause;
    logic                  abort;
    logic [LEVEL_W-1:0]    curLevel;
    logic                  busy;
    logic                  paused;
    logic                  done;
    logic [4*N_DIGITS-1:0] secsLeft;
    logic [8*N_DIGITS-1:0] seg;

    modport master (
        output Clk1Hz, start, pause, abort, curLevel,
        input  busy, paused, done, secsLeft, seg
    );

    modport slave (
        input  Clk1Hz, start, pause, abort, curLevel,
        output busy, paused, done, secsLeft, seg
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// One display digit: BCD nibble to active-low {dp,g..a}. The blank input
// suppresses the segments only, so a decimal point can still be shown.
module bcd_to_seg7
    import symcounter_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] seg
);
    assign seg = {~dp, blank ? 7'h7F : seg_lookup(nibble)};
endmodule

// File: rtl/period_countdown_seq.sv
// Level-scaled BCD countdown with pause/abort, edge-armed start and a
// registered multi-digit 7-segment output. Emits a 1-cycle done on expiry.
module period_countdown_seq
    import symcounter_pkg::*;
#(
    parameter int N_DIGITS  = 2,
    parameter int LEVEL_W   = 4,
    parameter int BASE_SECS = 10,
    parameter int STEP_SECS = 1,
    parameter int MIN_SECS  = 3,
    parameter int WARN_SECS = 3
) (
    input logic                   Clk100M,
    input logic                   Reset,
    period_countdown_seq_if.slave bus
);
    localparam int DW       = 4 * N_DIGITS;
    localparam int MAX_SECS = pow10(N_DIGITS) - 1;

    function automatic logic [DW-1:0] to_bcd(input int value);
        int            v;
        logic [DW-1:0] r;
        v = value;
        r = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam int            WARN_CLAMP = (WARN_SECS > MAX_SECS) ? MAX_SECS : WARN_SECS;
    localparam logic [DW-1:0] WARN_BCD   = to_bcd(WARN_CLAMP);

    state_t                state;
    logic [LEVEL_W-1:0]    level_q;
    logic [DW-1:0]         secs_left;
    logic                  busy;
    logic                  paused;
    logic                  done;
    logic [8*N_DIGITS-1:0] seg_q;
    logic [8*N_DIGITS-1:0] seg_next;
    logic                  clk1_meta;
    logic                  clk1_sync;
    logic                  clk1_prev;
    logic                  tick;
    logic                  start_q;
    logic                  start_edge;
    int                    dur;
    logic [DW-1:0]         load_bcd;
    logic [DW-1:0]         dec_bcd;
    logic                  borrow;
    logic                  dec_zero;
    logic                  warn;

    // Bring the slow clock into this domain and turn its rising edge into a tick.
    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            clk1_meta <= 1'b0;
            clk1_sync <= 1'b0;
            clk1_prev <= 1'b0;
        end else begin
            clk1_meta <= bus.Clk1Hz;
            clk1_sync <= clk1_meta;
            clk1_prev <= clk1_sync;
        end
    end

    assign tick = clk1_sync & ~clk1_prev;

    // Remember last start level so a held start arms only one run.
    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            start_q <= 1'b0;
        end else begin
            start_q <= bus.start;
        end
    end

    assign start_edge = bus.start & ~start_q;

    // Duration from the latched level: signed math, floored, then clipped to the display range.
    always_comb begin
        dur = BASE_SECS - int'(level_q) * STEP_SECS;
        if (dur < MIN_SECS) begin
            dur = MIN_SECS;
        end
        if (dur > MAX_SECS) begin
            dur = MAX_SECS;
        end
        load_bcd = to_bcd(dur);
    end

    // BCD decrement by one, rippling a borrow through digits that are already zero.
    always_comb begin
        dec_bcd = secs_left;
        borrow  = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (borrow) begin
                if (secs_left[4*i +: 4] == 4'd0) begin
                    dec_bcd[4*i +: 4] = 4'd9;
                end else begin
                    dec_bcd[4*i +: 4] = secs_left[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
        dec_zero = (dec_bcd == '0);
    end

    // Countdown sequencer; abort beats pause, pause beats tick.
    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            state     <= IDLE;
            level_q   <= '0;
            secs_left <= '0;
            busy      <= 1'b0;
            paused    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        level_q <= bus.curLevel;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        secs_left <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        secs_left <= load_bcd;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        secs_left <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (bus.pause) begin
                        paused <= 1'b1;
                        state  <= PAUSE;
                    end else if (tick) begin
                        secs_left <= dec_bcd;
                        if (dec_zero) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (bus.abort) begin
                        secs_left <= '0;
                        busy      <= 1'b0;
                        paused    <= 1'b0;
                        state     <= IDLE;
                    end else if (!bus.pause) begin
                        paused <= 1'b0;
                        state  <= RUN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    secs_left <= '0;
                    busy      <= 1'b0;
                    paused    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign warn = (secs_left <= WARN_BCD);

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        logic blank;
        logic dp;
        if (i == 0) begin : g_lsd
            assign blank = 1'b0;
        end else begin : g_msd
            assign blank = (secs_left[DW-1:4*i] == '0);
        end
        assign dp = (state == PAUSE) || ((i == 0) && (state == RUN) && warn);
        bcd_to_seg7 u_seg (
            .nibble (secs_left[4*i +: 4]),
            .blank  (blank),
            .dp     (dp),
            .seg    (seg_next[8*i +: 8])
        );
    end

    // Register the display so it trails secsLeft by one cycle; IDLE shows nothing.
    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            seg_q <= {N_DIGITS{SEG_BLANK}};
        end else if (state == IDLE) begin
            seg_q <= {N_DIGITS{SEG_BLANK}};
        end else begin
            seg_q <= seg_next;
        end
    end

    assign bus.busy     = busy;
    assign bus.paused   = paused;
    assign bus.done     = done;
    assign bus.secsLeft = secs_left;
    assign bus.seg      = seg_q;
endmodule
